// File: rtl/cache_arbiter_ctrl.sv
// Arbitrates I-cache and D-cache misses onto one unified memory port; D misses win, dirty victims are written back first.
// Optional performance counters are built when CACHE_PERF_CNT_EN is defined.
module cache_arbiter_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int OFFSET_W = 3,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rdy,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_acc,
    input  logic              d_rdy,
    input  logic              d_dirty,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [ADDR_W-1:0] d_victim_addr,
    input  logic              u_rdy,
    output logic              u_re,
    output logic              u_we,
    output logic [ADDR_W-1:0] u_addr,
    output logic              i_we,
    output logic              d_we,
    output logic              stall
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  i_miss_cnt,
    output logic [CNT_W-1:0]  d_miss_cnt,
    output logic [CNT_W-1:0]  wb_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        I_RD = 2'd1,
        D_WB = 2'd2,
        D_RD = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    state_t state;
    state_t state_next;
    logic   d_miss;

    assign d_miss = d_acc & ~d_rdy;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a latch behind.
    always_comb begin
        state_next = state;
        u_re       = 1'b0;
        u_we       = 1'b0;
        u_addr     = '0;
        i_we       = 1'b0;
        d_we       = 1'b0;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                // u_rdy is deliberately ignored here; the D side always wins a tie.
                stall = d_miss | ~i_rdy;
                if (d_miss && d_dirty) begin
                    state_next = D_WB;
                end else if (d_miss) begin
                    state_next = D_RD;
                end else if (!i_rdy) begin
                    state_next = I_RD;
                end
            end
            I_RD: begin
                stall  = 1'b1;
                u_re   = 1'b1;
                u_addr = i_addr & LINE_MASK;
                if (u_rdy) begin
                    i_we       = 1'b1;
                    state_next = IDLE;
                end
            end
            D_WB: begin
                stall  = 1'b1;
                u_we   = 1'b1;
                u_addr = d_victim_addr & LINE_MASK;
                if (u_rdy) begin
                    state_next = D_RD;
                end
            end
            D_RD: begin
                stall  = 1'b1;
                u_re   = 1'b1;
                u_addr = d_addr & LINE_MASK;
                if (u_rdy) begin
                    d_we       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef CACHE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Counters saturate rather than wrap so a long run never reads as a small count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_miss_cnt <= '0;
            d_miss_cnt <= '0;
            wb_cnt     <= '0;
        end else begin
            if (state == IDLE && state_next == I_RD && i_miss_cnt != CNT_MAX) begin
                i_miss_cnt <= i_miss_cnt + 1'b1;
            end
            if (state == IDLE && (state_next == D_RD || state_next == D_WB) && d_miss_cnt != CNT_MAX) begin
                d_miss_cnt <= d_miss_cnt + 1'b1;
            end
            if (state == D_WB && state_next == D_RD && wb_cnt != CNT_MAX) begin
                wb_cnt <= wb_cnt + 1'b1;
            end
        end
    end
`else
    // Without the counters the arbiter carries no extra state.
`endif

endmodule

// File: doc/cache_arbiter_ctrl.md
CACHE_ARBITER_CTRL -- requirements
Module: cache_arbiter_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16, byte-address width of every address port.
REQ-002 Parameter OFFSET_W, default 3, line-offset bits zeroed on u_addr (line = 2**OFFSET_W bytes).
REQ-003 Parameter CNT_W, default 16, width of each performance counter.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 i_rdy  in  1  I-cache hit for the current fetch; low = I-miss.
REQ-007 i_addr  in  ADDR_W  fetch address.
REQ-008 d_acc  in  1  data access (load or store) present this cycle.
REQ-009 d_rdy  in  1  D-cache hit; meaningful only when d_acc=1.
REQ-010 d_dirty  in  1  victim line of the missing D set is dirty.
REQ-011 d_addr  in  ADDR_W  data access address.
REQ-012 d_victim_addr  in  ADDR_W  address of the dirty victim line.
REQ-013 u_rdy  in  1  unified memory completes the current transaction (one-cycle pulse).
REQ-014 u_re  out  1  unified memory read request, held until u_rdy.
REQ-015 u_we  out  1  unified memory write-back request, held until u_rdy.
REQ-016 u_addr  out  ADDR_W  line-aligned transaction address; 0 when idle.
REQ-017 i_we  out  1  I-cache line-fill strobe.
REQ-018 d_we  out  1  D-cache line-fill strobe.
REQ-019 stall  out  1  pipeline stall request.
REQ-020 i_miss_cnt, d_miss_cnt, wb_cnt  out  CNT_W each  performance counters (present only under REQ-036).

Function
REQ-021 States SHALL be IDLE, I_RD, D_WB, D_RD; combinational outputs, registered state.
REQ-022 IDLE: d_miss = d_acc & ~d_rdy; if d_miss & d_dirty -> D_WB; else if d_miss -> D_RD; else if ~i_rdy -> I_RD; else stay IDLE.
REQ-023 Simultaneous I-miss and D-miss SHALL serve D first; the I-miss is re-evaluated in IDLE afterwards.
REQ-024 D_WB: u_we=1, u_addr=d_victim_addr aligned; on u_rdy -> D_RD.
REQ-025 D_RD: u_re=1, u_addr=d_addr aligned; on u_rdy assert d_we=1 that cycle and -> IDLE.
REQ-026 I_RD: u_re=1, u_addr=i_addr aligned; on u_rdy assert i_we=1 that cycle and -> IDLE.
REQ-027 u_re and u_we SHALL never be high together; i_we/d_we SHALL be one-cycle pulses only coincident with u_rdy.
REQ-028 stall SHALL be 1 in every non-IDLE state and combinationally 1 in IDLE when any miss is present.
REQ-029 u_rdy in IDLE SHALL be ignored; minimum miss penalty = 2 cycles (I_RD/D_RD entered next edge, u_rdy same cycle); dirty miss minimum 3.
REQ-030 Address inputs SHALL be sampled combinationally each cycle; the requester holds them stable while stall=1.
REQ-031 Unused state encodings SHALL transition to IDLE with all outputs deasserted.

Reset
REQ-032 rst=1 SHALL force IDLE immediately, regardless of clk.
REQ-033 During/after reset: u_re=0, u_we=0, u_addr=0, i_we=0, d_we=0; stall follows REQ-028 from inputs.
REQ-034 Reset mid-transaction SHALL abandon it; no fill strobe issued for the aborted transaction.
REQ-035 Counters SHALL reset to 0.

Configuration
REQ-036 Macro CACHE_PERF_CNT_EN defined: the three counters exist; i_miss_cnt +1 on IDLE->I_RD, d_miss_cnt +1 on IDLE->D_RD or IDLE->D_WB, wb_cnt +1 on D_WB->D_RD; each saturates at 2**CNT_W-1.
REQ-037 Macro undefined: counter ports and logic absent; all other behaviour identical.

Verification
REQ-038 i_rdy=0, d_acc=0, i_addr=0x1234; u_rdy 3 cycles after I_RD entry -> u_re=1 and u_addr=0x1230 for 3 cycles, i_wepulse once, IDLE after.
REQ-039 d_acc=1, d_rdy=0, d_dirty=1, d_victim_addr=0x8008, d_addr=0x4005 -> u_we with u_addr=0x8008, then u_re with u_addr=0x4000, d_we pulse, wb_cnt=1 (macro on).
REQ-040 i_rdy=0 and d_acc=1, d_rdy=0, d_dirty=0 together -> D_RD served first, then I_RD; d_miss_cnt=1, i_miss_cnt=1.
REQ-041 rst pulsed mid-D_RD, no clock edge -> u_re=0 immediately; later u_rdy produces no d_we.
REQ-042 CNT_W=2, five I-misses with macro on -> i_miss_cnt stays 3.
